clb_multi_ble: RTL
==================

# clb_multi_ble

Parametrised configurable logic block with N basic logic elements (BLEs), each a K-input LUT plus an optional output register, fed by a full input crossbar. Configuration is shifted serially into a shadow chain on the system clock. It is copied to the active configuration only on an explicit commit, so live logic is undisturbed while the next bitstream loads. The block sits in the FPGA fabric tile and is chained with other tiles through `scan_in`/`scan_out`.

## Interface
- `K`, 4: LUT inputs per BLE.
- `N`, 4: BLEs per CLB.
- `I`, 10: CLB input pins.
- `SEL_W`, 4: crossbar select width. Must satisfy 2^SEL_W ≥ I+N+1.
- Derived values:
  - BLE_BITS = 2^K + K·SEL_W + 1
  - CFG_BITS = N·BLE_BITS (132 at defaults)
- `clk` input 1: single clock for logic and configuration shifting.
- `reset` input 1: asynchronous, active-high.
- `scan_in` input 1: serial configuration bit.
- `scan_en` input 1: shift enable, one bit per `clk`.
- `cfg_commit` input 1: copy shadow to active config.
- `clb_in` input I: logic inputs.
- `out` output N: BLE outputs.
- `scan_out` output 1: shadow[CFG_BITS-1].
- `cfg_valid` output 1: active config loaded.
- `cfg_err` output 1: one-cycle pulse when a commit is rejected.

## Operation
- **Shadow chain.** When `scan_en`=1, each `clk` does shadow <= {shadow[CFG_BITS-2:0], scan_in}. The first bit shifted in ends up at the MSB.
- **Shift counter.** Width clog2(CFG_BITS+1). Increments per shifted bit and saturates at CFG_BITS.
- **Field layout.** BLE j occupies base = j·BLE_BITS:
  - LUT truth table at [base +: 2^K], indexed by the LUT input vector.
  - Select for LUT input k at [base+2^K+k·SEL_W +: SEL_W].
  - Mode bit at [base+BLE_BITS-1]: 1 = combinational, 0 = registered.
- **Crossbar sources:**
  - 0..I-1 = `clb_in`
  - I..I+N-1 = BLE register outputs `ff[0..N-1]`, not `out`, so there are no combinational loops
  - I+N = constant 0
  - any larger value = 0
- **Commit accepted:** `cfg_commit`=1, `scan_en`=0 and counter == CFG_BITS.
  - active <= shadow, `cfg_valid` <= 1, counter <= 0, all `ff` <= 0.
  - The shadow is retained, so a second commit without shifting is rejected.
- **Commit rejected:** counter < CFG_BITS, or `scan_en`=1 in the same cycle.
  - Active config is unchanged, `cfg_err` <= 1 for one cycle.
  - Any shift requested that cycle still occurs.
- **Over-shifting** (more than CFG_BITS bits) is legal. The last CFG_BITS bits are retained and the commit is accepted.
- **BLE register.** While `cfg_valid`=1, each `clk` loads `ff[j]` <= lut_out[j]. While `cfg_valid`=0, `ff` holds 0.
- **Output.** `out[j]` = `cfg_valid` ? (mode ? lut_out[j] : `ff[j]`) : 0.
- **Reset** asynchronously clears:
  - shadow, active config, counter, `ff`
  - `cfg_valid`, `cfg_err`
  - hence `out`=0 and `scan_out`=0

## Timing
- Combinational path: `clb_in` → `out` has zero-cycle latency in combinational mode and one cycle (through `ff`) in registered mode.
- `scan_out` changes one cycle after each shift edge. Chain latency through the block is CFG_BITS cycles.
- Commit sampled at edge t:
  - new config drives `out` immediately after t
  - `ff` is 0 after t and captures the new LUT value at t+1
- `cfg_err` is registered: high for exactly the cycle after the rejecting edge.
- Reset asserted mid-shift or mid-commit clears everything immediately with no clock needed. After deassertion, a full CFG_BITS reload is required.

## Test plan
All scenarios use the default parameters.
- **Reset:** assert `reset` → `out`=0, `cfg_valid`=0, `cfg_err`=0, `scan_out`=0. Commit with no shifting → `cfg_err` pulses once, `cfg_valid` stays 0.
- **Combinational AND:** shift 132 bits with BLE0 = 4-input AND of `clb_in[3:0]` (truth 0x8000, selects 0,1,2,3, mode 1), other BLEs LUT 0, then commit.
  - `clb_in`=0x00F → `out[0]`=1.
  - `clb_in`=0x007 → `out[0]`=0.
- **Short load:** shift 131 bits, then commit → `cfg_err`=1 for one cycle, `cfg_valid`=0, `out`=0. Shift one more bit and commit → accepted.
- **Registered feedback toggle:** BLE1 LUT = NOT of input 0, input 0 select = 11 (`ff[1]`), other selects 14, mode 0. After commit, `out[1]` reads 0,1,0,1 on successive cycles.
- **Live reload:** with the AND config active, shift a 132-bit OR config with `clb_in`=0x001 held.
  - `out[0]` stays 0 for all 132 cycles.
  - `scan_out` emits the previous bitstream MSB-first.
  - After commit, `out[0]`=1.
- **Reset and collision:** assert `reset` after 60 shifts → all state clears. Reload 132 bits, then assert `cfg_commit` together with `scan_en` → rejected with `cfg_err`.

Source files
------------

// File: rtl/clb_multi_ble_if.sv
// clb_multi_ble_if: configuration scan and logic I/O bundle of one CLB tile
interface clb_multi_ble_if #(
  parameter int I = 10,
  parameter int N = 4
);
  logic scan_in;
  logic scan_en;
  logic cfg_commit;
  logic [I-1:0] clb_in;
  logic [N-1:0] out;
  logic scan_out;
  logic cfg_valid;
  logic cfg_err;
  modport master(
    output scan_in, scan_en, cfg_commit, clb_in,
    input out, scan_out, cfg_valid, cfg_err
  );
  modport slave(
    input scan_in, scan_en, cfg_commit, clb_in,
    output out, scan_out, cfg_valid, cfg_err
  );
endinterface

// File: rtl/clb_multi_ble.sv
// clb_multi_ble: N K-LUT BLEs behind a full crossbar, with a shadow scan chain committed atomically
module clb_multi_ble #(
  parameter int K = 4,
  parameter int N = 4,
  parameter int I = 10,
  parameter int SEL_W = 4
) (
  input logic clk,
  input logic reset,
  clb_multi_ble_if.slave bus
);
  localparam int LUT_BITS = 1 << K;
  localparam int BLE_BITS = LUT_BITS + K * SEL_W + 1;
  localparam int CFG_BITS = N * BLE_BITS;
  localparam int CNT_W = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);
  logic [CFG_BITS-1:0] shadow, active;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0] ff, lut_out, mode;
  logic [(1<<SEL_W)-1:0] src;
  logic valid, err, full, accept, reject;
  assign full = cnt == CNT_MAX;
  assign accept = bus.cfg_commit && !bus.scan_en && full;
  assign reject = bus.cfg_commit && !accept;
  // Feedback comes from ff only, so the crossbar can never close a combinational loop
  always_comb begin
    src = '0;
    src[I-1:0] = bus.clb_in;
    src[I+N-1:I] = ff;
  end
  for (genvar j = 0; j < N; j++) begin : g_ble
    logic [K-1:0] idx;
    logic [LUT_BITS-1:0] lut;
    always_comb
      for (int k = 0; k < K; k++)
        idx[k] = src[active[j*BLE_BITS+LUT_BITS+k*SEL_W +: SEL_W]];
    assign lut = active[j*BLE_BITS +: LUT_BITS];
    assign lut_out[j] = lut[idx];
    assign mode[j] = active[j*BLE_BITS+BLE_BITS-1];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shadow <= '0;
      active <= '0;
      cnt <= '0;
      ff <= '0;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      if (bus.scan_en) begin
        shadow <= {shadow[CFG_BITS-2:0], bus.scan_in};
        if (!full) cnt <= cnt + 1'b1;
      end
      err <= reject;
      if (accept) begin
        active <= shadow;
        valid <= 1'b1;
        cnt <= '0;
        ff <= '0;
      end else ff <= valid ? lut_out : '0;
    end
  assign bus.out = valid ? (mode & lut_out | ~mode & ff) : '0;
  assign bus.scan_out = shadow[CFG_BITS-1];
  assign bus.cfg_valid = valid;
  assign bus.cfg_err = err;
endmodule
